multi_input_sync: RTL and testbench

//  Multi-channel input conditioner for asynchronous pins (JTAG TCK/TMS/TDI/TRST, buttons) entering the internal clock domain.
//  Per channel: a parametrised-depth synchroniser chain, then a stability (glitch) filter.

---
 rtl/msync_pkg.sv | 18 +
 rtl/msync_glitch_filter.sv | 70 +++++++
 rtl/multi_input_sync.sv | 55 +++++
 tb/tb_multi_input_sync.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/msync_pkg.sv
// Shared constants, counter sizing and filter-state type for the multi-input synchroniser.
package msync_pkg;

  localparam int MSYNC_MIN_STAGES = 2;
  localparam int MSYNC_MIN_FILTER = 1;

  typedef enum logic {
    MSYNC_STABLE,
    MSYNC_COUNTING
  } msync_state_e;

  function automatic int cnt_width(input int f);
    int w;
    w = $clog2(f);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/msync_glitch_filter.sv
// One channel: synchroniser chain, stability counter, optional registered edge pulses.
// Edge outputs exist only when MSYNC_EDGE_DETECT_EN is defined.
module msync_glitch_filter
  import msync_pkg::*;
#(
  parameter int   STAGES        = 3,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level
`ifdef MSYNC_EDGE_DETECT_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [STAGES-1:0] stage;
  logic              synced;
  logic [CW-1:0]     cnt;
  logic              flip;
  msync_state_e      state;

  assign synced = stage[STAGES-1];
  assign flip   = (synced != level) && (cnt == CNT_MAX);
  assign state  = (cnt == '0) ? MSYNC_STABLE : MSYNC_COUNTING;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= {STAGES{RESET_VAL}};
      level <= RESET_VAL;
      cnt   <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], pad};
      if (synced == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef MSYNC_EDGE_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip & synced;
      fall <= flip & ~synced;
    end
  end

  a_edge_excl: assert property (@(posedge clk) disable iff (rst) !(rise && fall));
`endif

  // With real filtering, a channel sitting idle cannot flip on the very next edge.
  a_stable_hold: assert property (@(posedge clk) disable iff (rst)
    (state == MSYNC_STABLE && CNT_MAX != '0) |=> $stable(level));

endmodule

// File: rtl/multi_input_sync.sv
// Multi-channel pad conditioner: per-channel sync chain + glitch filter.
// Optional edge pulses and any_change output when MSYNC_EDGE_DETECT_EN is defined.
module multi_input_sync
  import msync_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  STAGES        = 3,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
  input  logic                msync_internal_clk,
  input  logic                msync_rst,
  input  logic [CHANNELS-1:0] msync_in_signal,
  output logic [CHANNELS-1:0] msync_out_signal
`ifdef MSYNC_EDGE_DETECT_EN
  ,
  output logic [CHANNELS-1:0] msync_rise,
  output logic [CHANNELS-1:0] msync_fall,
  output logic                msync_any_change
`endif
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("multi_input_sync: CHANNELS must be >= 1");
  end
  if (STAGES < MSYNC_MIN_STAGES) begin : g_bad_stages
    $error("multi_input_sync: STAGES must be >= %0d", MSYNC_MIN_STAGES);
  end
  if (FILTER_CYCLES < MSYNC_MIN_FILTER) begin : g_bad_filter
    $error("multi_input_sync: FILTER_CYCLES must be >= %0d", MSYNC_MIN_FILTER);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    msync_glitch_filter #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VAL     (RESET_VAL[i])
    ) u_filter (
      .clk   (msync_internal_clk),
      .rst   (msync_rst),
      .pad   (msync_in_signal[i]),
      .level (msync_out_signal[i])
`ifdef MSYNC_EDGE_DETECT_EN
      ,
      .rise  (msync_rise[i]),
      .fall  (msync_fall[i])
`endif
    );
  end

`ifdef MSYNC_EDGE_DETECT_EN
  assign msync_any_change = |(msync_rise | msync_fall);
`endif

endmodule

// File: tb/tb_multi_input_sync.sv
// Bench for multi_input_sync: default instance plus a STAGES=2/FILTER_CYCLES=1 instance.
// Edge-pulse checks are compiled in only when MSYNC_EDGE_DETECT_EN is defined.
module tb_multi_input_sync;

  logic       clk;
  logic       rst;
  logic [3:0] in_sig;
  logic [1:0] in2;
  logic [3:0] out1;
  logic [1:0] out2;
`ifdef MSYNC_EDGE_DETECT_EN
  logic [3:0] rise1, fall1;
  logic [1:0] rise2, fall2;
  logic       any1, any2;
`endif

  int total = 0;
  int bad   = 0;

  // Second instance sees ch1 inverted so that all-zero stimulus equals its reset level.
  assign in2 = in_sig[1:0] ^ 2'b10;

  multi_input_sync u_dut (
    .msync_internal_clk (clk),
    .msync_rst          (rst),
    .msync_in_signal    (in_sig),
    .msync_out_signal   (out1)
`ifdef MSYNC_EDGE_DETECT_EN
    ,
    .msync_rise         (rise1),
    .msync_fall         (fall1),
    .msync_any_change   (any1)
`endif
  );

  multi_input_sync #(
    .CHANNELS      (2),
    .STAGES        (2),
    .FILTER_CYCLES (1),
    .RESET_VAL     (2'b10)
  ) u_dut2 (
    .msync_internal_clk (clk),
    .msync_rst          (rst),
    .msync_in_signal    (in2),
    .msync_out_signal   (out2)
`ifdef MSYNC_EDGE_DETECT_EN
    ,
    .msync_rise         (rise2),
    .msync_fall         (fall2),
    .msync_any_change   (any2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a delay line of STAGES samples, then a run-length rule
  // (FILTER consecutive disagreeing samples adopt the new level).
  logic [3:0] dq0[$];
  logic [3:0] dq1[$];
  logic [3:0] m_out[2];
  logic [3:0] m_rise[2];
  logic [3:0] m_fall[2];
  int         m_run[2][4];

  task automatic model_reset();
    dq0.delete();
    dq1.delete();
    repeat (3) dq0.push_back(4'h0);
    repeat (2) dq1.push_back(4'b0010);
    m_out[0] = 4'h0;
    m_out[1] = 4'b0010;
    for (int d = 0; d < 2; d++) begin
      m_rise[d] = '0;
      m_fall[d] = '0;
      for (int c = 0; c < 4; c++) m_run[d][c] = 0;
    end
  endtask

  task automatic filt(input int d, input logic [3:0] s, input int f, input int n);
    m_rise[d] = '0;
    m_fall[d] = '0;
    for (int c = 0; c < n; c++) begin
      if (s[c] == m_out[d][c]) begin
        m_run[d][c] = 0;
      end else begin
        m_run[d][c] = m_run[d][c] + 1;
        if (m_run[d][c] == f) begin
          m_out[d][c] = s[c];
          m_run[d][c] = 0;
          if (s[c]) m_rise[d][c] = 1'b1;
          else      m_fall[d][c] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_step();
    logic [3:0] s;
    s = dq0.pop_front();
    dq0.push_back(in_sig);
    filt(0, s, 4, 4);
    s = dq1.pop_front();
    dq1.push_back({2'b00, in2});
    filt(1, s, 1, 2);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("model_out", out1, m_out[0]);
    chk("model_out2", {2'b00, out2}, m_out[1]);
`ifdef MSYNC_EDGE_DETECT_EN
    chk("model_rise", rise1, m_rise[0]);
    chk("model_fall", fall1, m_fall[0]);
    chk("model_any", {3'b000, any1}, {3'b000, |(m_rise[0] | m_fall[0])});
    chk("model_rise2", {2'b00, rise2}, m_rise[1]);
    chk("model_fall2", {2'b00, fall2}, m_fall[1]);
    chk("model_any2", {3'b000, any2}, {3'b000, |(m_rise[1] | m_fall[1])});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [3:0] in;
    int         cycles;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{4'h1, 6,  4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h1, 1,  4'h1, 4'h1, 4'h0});
    tbl.push_back('{4'h1, 1,  4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'h3, 3,  4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'h1, 10, 4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'h3, 4,  4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'h1, 2,  4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'h1, 1,  4'h3, 4'h2, 4'h0});
    tbl.push_back('{4'h1, 3,  4'h3, 4'h0, 4'h0});
    tbl.push_back('{4'h1, 1,  4'h1, 4'h0, 4'h2});
    tbl.push_back('{4'h0, 6,  4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'h0, 1,  4'h0, 4'h0, 4'h1});
    tbl.push_back('{4'h9, 6,  4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 1,  4'h9, 4'h9, 4'h0});
    tbl.push_back('{4'h9, 1,  4'h9, 4'h0, 4'h0});
    tbl.push_back('{4'h8, 6,  4'h9, 4'h0, 4'h0});
    tbl.push_back('{4'h8, 1,  4'h8, 4'h0, 4'h1});

    rst    = 1'b1;
    in_sig = 4'h0;
    model_reset();

    // Reset held while pads toggle.
    repeat (10) begin
      in_sig = 4'($urandom);
      tick();
      chk("rst_hold_out", out1, 4'h0);
      chk("rst_hold_out2", {2'b00, out2}, 4'b0010);
    end
    in_sig = 4'h0;
    rst    = 1'b0;
    repeat (20) begin
      tick();
      chk("post_rst_out", out1, 4'h0);
`ifdef MSYNC_EDGE_DETECT_EN
      chk("post_rst_pulse", rise1 | fall1, 4'h0);
      chk("post_rst_pulse2", {2'b00, rise2 | fall2}, 4'h0);
`endif
    end

    foreach (tbl[i]) begin
      in_sig = tbl[i].in;
      repeat (tbl[i].cycles) tick();
      chk($sformatf("tbl%0d_out", i), out1, tbl[i].out);
`ifdef MSYNC_EDGE_DETECT_EN
      chk($sformatf("tbl%0d_rise", i), rise1, tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), fall1, tbl[i].fall);
      chk($sformatf("tbl%0d_any", i), {3'b000, any1}, {3'b000, |(tbl[i].rise | tbl[i].fall)});
`endif
    end

    // Reset while ch0 is mid-count; ch3 is high and must drop immediately.
    in_sig = 4'h9;
    repeat (5) tick();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_out", out1, 4'h0);
    chk("rst_async_out2", {2'b00, out2}, 4'b0010);
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("rst_relatch_early", out1, 4'h0);
    tick();
    chk("rst_relatch_out", out1, 4'h9);

    // Short-chain instance: three-edge latency on ch0 falling.
    repeat (4) tick();
    chk("lat3_before", {2'b00, out2}, 4'b0011);
    in_sig = 4'h8;
    repeat (2) tick();
    chk("lat3_edge2", {2'b00, out2}, 4'b0011);
    tick();
    chk("lat3_edge3", {2'b00, out2}, 4'b0010);

    // Random bouncing pads with one asynchronous reset pulse.
    for (int i = 0; i < 400; i++) begin
      in_sig = in_sig ^ (4'($urandom) & 4'($urandom));
      if (i == 200) begin
        rst = 1'b1;
        model_reset();
      end
      if (i == 203) rst = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
